// File: rtl/step_control_if.sv
// rtl/step_control_if.sv - datapath control bundle between step_control and the CPU datapath
interface step_control_if;
    logic        run;
    logic [31:0] IR;
    logic        mem_rdy;

    logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin;
    logic Gra, Grb, Grc, Rin, Rout;
    logic ADD, SUB, AND, OR, MUL, DIV;
    logic LOin, HIin;
    logic busy, done, halted, illegal;

    modport master (
        input  run, IR, mem_rdy,
        output PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin,
        output Gra, Grb, Grc, Rin, Rout,
        output ADD, SUB, AND, OR, MUL, DIV,
        output LOin, HIin,
        output busy, done, halted, illegal
    );

    modport slave (
        output run, IR, mem_rdy,
        input  PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin,
        input  Gra, Grb, Grc, Rin, Rout,
        input  ADD, SUB, AND, OR, MUL, DIV,
        input  LOin, HIin,
        input  busy, done, halted, illegal
    );
endinterface

// File: rtl/step_control.sv
// rtl/step_control.sv - fetch/execute control sequencer for ALU, MUL and DIV instructions
// Optional feature macro: CTRL_DIV_EN (opcode 10000 executes as DIV instead of being illegal).
module step_control (
    input logic            clk,
    input logic            clr,
    step_control_if.master bus
);
    typedef enum logic [3:0] {
        IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT
    } state_t;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    state_t     state, state_next;
    logic       illegal_q;
    logic       set_illegal;
    logic [4:0] opcode;
    logic       is_alu, is_hilo, div_sel;
    logic       unused_ir;

    assign opcode    = bus.IR[31:27];
    // Register fields are consumed by the select-and-encode logic, not here.
    assign unused_ir = ^bus.IR[26:0];

    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                    (opcode == OP_AND) || (opcode == OP_OR);

`ifdef CTRL_DIV_EN
    localparam logic [4:0] OP_DIV = 5'b10000;
    assign div_sel = (opcode == OP_DIV);
    assign is_hilo = (opcode == OP_MUL) || div_sel;
`else
    assign div_sel = 1'b0;
    assign is_hilo = (opcode == OP_MUL);
`endif

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next   = state;
        set_illegal  = 1'b0;
        bus.PCout    = 1'b0;
        bus.MARin    = 1'b0;
        bus.IncPC    = 1'b0;
        bus.Zin      = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        bus.PCin     = 1'b0;
        bus.Read     = 1'b0;
        bus.MDRin    = 1'b0;
        bus.MDRout   = 1'b0;
        bus.IRin     = 1'b0;
        bus.Yin      = 1'b0;
        bus.Gra      = 1'b0;
        bus.Grb      = 1'b0;
        bus.Grc      = 1'b0;
        bus.Rin      = 1'b0;
        bus.Rout     = 1'b0;
        bus.ADD      = 1'b0;
        bus.SUB      = 1'b0;
        bus.AND      = 1'b0;
        bus.OR       = 1'b0;
        bus.MUL      = 1'b0;
        bus.DIV      = 1'b0;
        bus.LOin     = 1'b0;
        bus.HIin     = 1'b0;
        bus.done     = 1'b0;
        bus.busy     = (state != IDLE) && (state != HALT);
        bus.halted   = (state == HALT);
        bus.illegal  = illegal_q;

        case (state)
            IDLE: begin
                if (bus.run) begin
                    state_next = T0;
                end
            end
            T0: begin
                bus.PCout  = 1'b1;
                bus.MARin  = 1'b1;
                bus.IncPC  = 1'b1;
                bus.Zin    = 1'b1;
                state_next = T1;
            end
            // PC is written only here so a stalled fetch cannot increment it twice.
            T1: begin
                bus.Zlowout = 1'b1;
                bus.PCin    = 1'b1;
                bus.Read    = 1'b1;
                bus.MDRin   = 1'b1;
                state_next  = bus.mem_rdy ? T2 : T1W;
            end
            T1W: begin
                bus.Read   = 1'b1;
                bus.MDRin  = 1'b1;
                state_next = bus.mem_rdy ? T2 : T1W;
            end
            T2: begin
                bus.MDRout = 1'b1;
                bus.IRin   = 1'b1;
                state_next = T3;
            end
            T3: begin
                if (is_alu || is_hilo) begin
                    bus.Grb    = 1'b1;
                    bus.Rout   = 1'b1;
                    bus.Yin    = 1'b1;
                    state_next = T4;
                end else begin
                    bus.done    = 1'b1;
                    set_illegal = (opcode != OP_NOP) && (opcode != OP_HALT);
                    state_next  = (opcode == OP_HALT) ? HALT : IDLE;
                end
            end
            T4: begin
                bus.Grc    = 1'b1;
                bus.Rout   = 1'b1;
                bus.Zin    = 1'b1;
                bus.ADD    = (opcode == OP_ADD);
                bus.SUB    = (opcode == OP_SUB);
                bus.AND    = (opcode == OP_AND);
                bus.OR     = (opcode == OP_OR);
                bus.MUL    = (opcode == OP_MUL);
                bus.DIV    = div_sel;
                state_next = T5;
            end
            T5: begin
                bus.Zlowout = 1'b1;
                if (is_hilo) begin
                    bus.LOin   = 1'b1;
                    state_next = T6;
                end else begin
                    bus.Gra    = 1'b1;
                    bus.Rin    = 1'b1;
                    bus.done   = 1'b1;
                    state_next = IDLE;
                end
            end
            T6: begin
                bus.Zhighout = 1'b1;
                bus.HIin     = 1'b1;
                bus.done     = 1'b1;
                state_next   = IDLE;
            end
            HALT: begin
                state_next = HALT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_step_control.sv
// tb/tb_step_control.sv - self-checking bench for step_control: directed table, corner sequences, random model check
module tb_step_control;
    logic clk = 1'b0;
    logic clr;
    int   errors = 0;
    int   checks = 0;

    step_control_if bus ();
    step_control dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

`ifdef CTRL_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    typedef struct packed {
        logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin;
        logic Gra, Grb, Grc, Rin, Rout;
        logic ADD, SUB, AND, OR, MUL, DIV;
        logic LOin, HIin;
        logic busy, done, halted;
    } outs_t;

    typedef struct {
        logic [31:0] ir;
        int          waits;
        int          lat;
        int          pcin;
        int          rin;
        int          lo;
        int          hi;
        bit          ill;
    } vec_t;

    outs_t exp_q[$];
    bit    model_ill  = 1'b0;
    bit    model_halt = 1'b0;

    function automatic outs_t sample();
        outs_t o;
        o = '{bus.PCout, bus.MARin, bus.IncPC, bus.Zin, bus.Zlowout, bus.Zhighout, bus.PCin,
              bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin,
              bus.Gra, bus.Grb, bus.Grc, bus.Rin, bus.Rout,
              bus.ADD, bus.SUB, bus.AND, bus.OR, bus.MUL, bus.DIV,
              bus.LOin, bus.HIin, bus.busy, bus.done, bus.halted};
        return o;
    endfunction

    function automatic bit is_alu_op(input logic [4:0] op);
        return (op == 5'd3) || (op == 5'd4) || (op == 5'd5) || (op == 5'd6);
    endfunction

    function automatic bit is_hilo_op(input logic [4:0] op);
        return (op == 5'd15) || (DIV_EN && op == 5'd16);
    endfunction

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic check_outs(input string name, input outs_t want);
        outs_t got;
        got = sample();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
        checks++;
        if (bus.illegal !== model_ill) begin
            errors++;
            $display("FAIL %s_illegal: got %b want %b", name, bus.illegal, model_ill);
        end
    endtask

    // Expected strobe script for one instruction, one entry per clock after leaving IDLE.
    task automatic build_exp(input logic [4:0] op, input int waits);
        outs_t c;
        exp_q.delete();
        c = '0; c.PCout = 1; c.MARin = 1; c.IncPC = 1; c.Zin = 1; c.busy = 1; exp_q.push_back(c);
        c = '0; c.Zlowout = 1; c.PCin = 1; c.Read = 1; c.MDRin = 1; c.busy = 1; exp_q.push_back(c);
        for (int i = 0; i < waits; i++) begin
            c = '0; c.Read = 1; c.MDRin = 1; c.busy = 1; exp_q.push_back(c);
        end
        c = '0; c.MDRout = 1; c.IRin = 1; c.busy = 1; exp_q.push_back(c);
        if (is_alu_op(op) || is_hilo_op(op)) begin
            c = '0; c.Grb = 1; c.Rout = 1; c.Yin = 1; c.busy = 1; exp_q.push_back(c);
            c = '0; c.Grc = 1; c.Rout = 1; c.Zin = 1; c.busy = 1;
            c.ADD = (op == 5'd3); c.SUB = (op == 5'd4); c.AND = (op == 5'd5);
            c.OR  = (op == 5'd6); c.MUL = (op == 5'd15); c.DIV = (op == 5'd16);
            exp_q.push_back(c);
            if (is_alu_op(op)) begin
                c = '0; c.Zlowout = 1; c.Gra = 1; c.Rin = 1; c.done = 1; c.busy = 1; exp_q.push_back(c);
            end else begin
                c = '0; c.Zlowout = 1; c.LOin = 1; c.busy = 1; exp_q.push_back(c);
                c = '0; c.Zhighout = 1; c.HIin = 1; c.done = 1; c.busy = 1; exp_q.push_back(c);
            end
        end else begin
            c = '0; c.done = 1; c.busy = 1; exp_q.push_back(c);
        end
    endtask

    function automatic outs_t rest_outs();
        outs_t c;
        c = '0;
        c.halted = model_halt;
        return c;
    endfunction

    // Runs one instruction from IDLE, checking every cycle; clr_at >= 0 pulses clr in that cycle.
    task automatic run_instr(input logic [31:0] ir, input int waits, input int clr_at,
                             output int lat, output int pcin_n, output int rin_n,
                             output int lo_n, output int hi_n);
        logic [4:0] op;
        bit         cleared;
        op = ir[31:27];
        cleared = 1'b0;
        lat = 0; pcin_n = 0; rin_n = 0; lo_n = 0; hi_n = 0;
        build_exp(op, waits);
        check_outs("idle_pre", rest_outs());
        bus.IR      = ir;
        bus.run     = 1'b1;
        bus.mem_rdy = 1'($urandom);
        @(posedge clk); @(negedge clk);
        for (int k = 0; k < exp_q.size(); k++) begin
            check_outs($sformatf("op%0h_cyc%0d", op, k), exp_q[k]);
            pcin_n += int'(bus.PCin);
            rin_n  += int'(bus.Rin);
            lo_n   += int'(bus.LOin);
            hi_n   += int'(bus.HIin);
            if (bus.done) lat = k + 1;
            if (k >= 1 && k < 1 + waits) bus.mem_rdy = 1'b0;
            else if (k == 1 + waits)     bus.mem_rdy = 1'b1;
            else                         bus.mem_rdy = 1'($urandom);
            bus.run = 1'($urandom);
            clr = (k == clr_at);
            @(posedge clk); @(negedge clk);
            clr = 1'b0;
            if (k == clr_at) begin
                cleared = 1'b1;
                model_ill = 1'b0;
                break;
            end
        end
        if (!cleared) begin
            if (!is_alu_op(op) && !is_hilo_op(op) && op != 5'd26 && op != 5'd27) model_ill = 1'b1;
            if (op == 5'd27) model_halt = 1'b1;
        end
        bus.run = 1'b0;
        check_outs($sformatf("op%0h_post", op), rest_outs());
    endtask

    task automatic do_clr();
        clr = 1'b1;
        bus.run = 1'b1;
        @(posedge clk); @(negedge clk);
        clr = 1'b0;
        bus.run = 1'b0;
        model_ill = 1'b0;
        model_halt = 1'b0;
        check_outs("after_clr", rest_outs());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int lat, pc, rn, lo, hi;
        logic [31:0] r;
        logic [4:0]  op;
        int w, el;

        tbl[0] = '{32'h28918000, 0, 6, 1, 1, 0, 0, 1'b0};
        tbl[1] = '{32'h78228000, 0, 7, 1, 0, 1, 1, 1'b0};
        tbl[2] = '{32'h18918000, 3, 9, 1, 1, 0, 0, 1'b0};
        tbl[3] = '{32'h20918000, 1, 7, 1, 1, 0, 0, 1'b0};
        tbl[4] = '{32'h30918000, 0, 6, 1, 1, 0, 0, 1'b0};
        tbl[5] = '{32'hD0000000, 2, 6, 1, 0, 0, 0, 1'b0};
        if (DIV_EN) tbl[6] = '{32'h80228000, 0, 7, 1, 0, 1, 1, 1'b0};
        else        tbl[6] = '{32'h80228000, 0, 4, 1, 0, 0, 0, 1'b1};

        clr = 1'b1;
        bus.run = 1'b0;
        bus.IR = '0;
        bus.mem_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset", rest_outs());
        clr = 1'b0;
        @(negedge clk);
        check_outs("idle_no_run", rest_outs());

        for (int i = 0; i < 7; i++) begin
            run_instr(tbl[i].ir, tbl[i].waits, -1, lat, pc, rn, lo, hi);
            check_int($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            check_int($sformatf("tbl%0d_pcin", i), pc, tbl[i].pcin);
            check_int($sformatf("tbl%0d_rin", i), rn, tbl[i].rin);
            check_int($sformatf("tbl%0d_loin", i), lo, tbl[i].lo);
            check_int($sformatf("tbl%0d_hiin", i), hi, tbl[i].hi);
            check_int($sformatf("tbl%0d_illegal", i), int'(bus.illegal), int'(tbl[i].ill));
        end
        do_clr();

        // Illegal opcode then halt: HALT ignores run, clr recovers and clears illegal.
        run_instr(32'h00000000, 0, -1, lat, pc, rn, lo, hi);
        check_int("illegal_set", int'(bus.illegal), 1);
        run_instr(32'hD8000000, 1, -1, lat, pc, rn, lo, hi);
        check_int("halt_latency", lat, 5);
        for (int i = 0; i < 4; i++) begin
            bus.run = ~bus.run;
            bus.mem_rdy = 1'($urandom);
            @(posedge clk); @(negedge clk);
            check_outs($sformatf("halt_hold%0d", i), rest_outs());
        end
        do_clr();
        check_int("illegal_cleared", int'(bus.illegal), 0);

        // clr in T4 of an add, with illegal previously set.
        run_instr(32'h08000000, 0, -1, lat, pc, rn, lo, hi);
        run_instr(32'h18918000, 0, 4, lat, pc, rn, lo, hi);
        check_int("clr_t4_rin", rn, 0);
        check_int("clr_t4_loin", lo, 0);
        check_int("clr_t4_illegal", int'(bus.illegal), 0);
        run_instr(32'h18918000, 0, -1, lat, pc, rn, lo, hi);
        check_int("after_clr_add_latency", lat, 6);
        check_int("after_clr_add_rin", rn, 1);

        for (int n = 0; n < 60; n++) begin
            r  = $urandom;
            op = 5'($urandom_range(0, 31));
            if (op == 5'd27) op = 5'd26;
            if (n % 4 == 0) op = 5'($urandom_range(3, 6));
            r[31:27] = op;
            w = $urandom_range(0, 3);
            run_instr(r, w, -1, lat, pc, rn, lo, hi);
            el = w + (is_alu_op(op) ? 6 : (is_hilo_op(op) ? 7 : 4));
            check_int($sformatf("rnd%0d_latency", n), lat, el);
            check_int($sformatf("rnd%0d_pcin", n), pc, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/step_control.md
# step_control

Multi-cycle control sequencer for the CPU datapath. It steps through fetch (T0–T2) and execute (T3–T6) for register-register ALU, MUL and DIV instructions. At each step it drives the datapath strobes (PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin, ALU op lines, LOin, HIin) plus the register-select strobes consumed by the select-and-encode logic. It replaces the hand-sequenced strobes of the per-instruction benches and owns the datapath from instruction fetch to writeback.

## Interface
Parameters:
- none

Ports:
- clk  in  1  system clock; all state changes on rising edge
- clr  in  1  synchronous, active-high reset
- run  in  1  when high in IDLE, starts the next fetch
- IR  in  32  instruction register contents; opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15]
- mem_rdy  in  1  memory read data valid on Mdatain this cycle
- PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-field select and register in/out strobes
- ADD, SUB, AND, OR, MUL, DIV  out  1 each  ALU operation select; at most one high
- LOin, HIin  out  1 each  LO/HI register load
- busy  out  1  high in every state except IDLE and HALT
- done  out  1  one-cycle pulse in the final execute step
- halted  out  1  high in HALT
- illegal  out  1  sticky; set on an unsupported opcode, cleared only by clr

## Operation
- Opcodes:
  - add 00011, sub 00100, and 00101, or 00110: ALU class
  - mul 01111, div 10000: HI/LO class
  - nop 11010
  - halt 11011
  - any other opcode is illegal
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, T6, HALT.
- Moore outputs: every strobe is a pure decode of the state register and the IR opcode. All outputs are 0 in IDLE and HALT.
- Per-state strobes and transitions:
  - IDLE → T0 when run=1; otherwise stay in IDLE.
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin. Go to T2 if mem_rdy=1, else to T1W.
  - T1W: Read, MDRin only. Stay while mem_rdy=0; go to T2 when mem_rdy=1.
  - T2: MDRout, IRin. Decode in T3 uses the updated IR.
  - T3 by opcode:
    - ALU or HI/LO class: Grb, Rout, Yin → T4.
    - nop: done → IDLE.
    - halt: done → HALT.
    - illegal: set illegal, done → IDLE.
  - T4: Grc, Rout, Zin, plus the opcode's op line (ADD/SUB/AND/OR/MUL/DIV) → T5.
  - T5, ALU class: Zlowout, Gra, Rin, done → IDLE.
  - T5, HI/LO class: Zlowout, LOin → T6.
  - T6: Zhighout, HIin, done → IDLE.
  - HALT: stays until clr; run is ignored.
- Instructions are not overlapped. The next fetch starts only after passing through IDLE, where run is sampled.

## Timing
- Reset: clr high at a rising edge forces IDLE on that edge. This applies from any state, including T1W and mid-execute. All outputs are 0 the following cycle and illegal clears.
- Latency from leaving IDLE, with mem_rdy=1 in T1:
  - ALU class: 6 cycles (T0–T5), done in T5.
  - MUL/DIV: 7 cycles (T0–T6), done in T6.
  - nop, halt, illegal: 4 cycles (T0–T3).
- Each memory wait cycle in T1W adds exactly 1 cycle.
- Zlowout and PCin are asserted only in T1, never in T1W, so PC is written exactly once per fetch.
- run high in the same cycle done is high has no effect. run is sampled only in IDLE, so back-to-back instructions spend 1 IDLE cycle between them.
- mem_rdy is ignored outside T1/T1W.

## Configuration
- CTRL_DIV_EN defined: opcode 10000 is HI/LO class and asserts DIV in T4.
- CTRL_DIV_EN undefined:
  - DIV is tied to 0.
  - Opcode 10000 is illegal: illegal is set, no register, LO or HI write, → IDLE after T3.

## Test plan
- and R1,R2,R3 (IR=0x28918000), mem_rdy=1, run pulsed: states T0..T5 in 6 cycles; T4 asserts AND+Grc+Rout+Zin; T5 asserts Gra+Rin+done; R1=0x12&0x14=0x10.
- mul R4,R5 (IR=0x78228000), R4=-4, R5=-5: T4 asserts MUL; T5 LOin with LO=20; T6 HIin with HI=0; done in cycle 7.
- mem_rdy held low 3 cycles in fetch: T1 for 1 cycle, T1W for 3 cycles; PCin high exactly once; total ALU latency 9.
- div (IR=0x80228000), R4=20, R5=3: with CTRL_DIV_EN, LO=6 and HI=2. Without it, illegal=1 after T3, LOin and HIin never asserted.
- halt (IR=0xD8000000): HALT after T3, halted=1, run pulses ignored. clr → IDLE, all outputs 0.
- clr asserted during T4 of an add: IDLE next cycle; Rin and LOin never asserted; illegal=0; a subsequent run fetch proceeds normally.
